instr_loader: RTL and testbench

Program loader for the MIPS instruction memory. Packs a byte stream from the UART receiver into 32-bit instruction words and writes them into consecutive word addresses of the instruction RAM, starting at address 0. Loading ends when the halt word (all ones) has been written. The block sits directly upstream of the instruction RAM write port and drives it only while a load is in progress.

---
 rtl/mips_pkg.sv | 15 +
 rtl/instr_loader_byte_packer.sv | 49 ++++
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: the halt word that ends a program image and the
// loader state encoding.
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word packer. o_word_valid pulses combinationally with the
// byte that completes a word; o_word holds the completed word until the next one.
module byte_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_accept,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_valid
);

    localparam int BYTES   = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W   = $clog2(BYTES);
    localparam int SHIFT_W = DATA_WIDTH - BYTE_WIDTH;

    logic [SHIFT_W-1:0]    r_shift;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_last;

    assign w_last       = i_accept && (r_byte_cnt == CNT_W'(BYTES - 1));
    assign o_word_valid = w_last;
    assign o_word       = r_word;

    // Only the first BYTES-1 bytes are held; the final byte goes straight into r_word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_accept) begin
            if (w_last) begin
                r_word     <= {r_shift, i_byte};
                r_byte_cnt <= '0;
            end else begin
                r_shift    <= {r_shift[SHIFT_W-BYTE_WIDTH-1:0], i_byte};
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a UART byte stream into instruction RAM, one word per completed group
// of four bytes, from address 0 until the halt word has been written.
//
// state | meaning
// IDLE  | after reset, waiting for i_start
// RECV  | packing bytes into the next word
// WRITE | one-cycle RAM write of the completed word
// DONE  | halt word written; waiting for i_start
// ERR   | RAM filled without a halt word; waiting for i_start
module instr_loader
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RAM_DEPTH  = 2048,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    output logic [DATA_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    output logic                  o_ram_en,
    output logic                  o_loading,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [CNT_WIDTH-1:0]  o_word_count
);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [CNT_WIDTH-1:0]  r_word_count;
    logic [DATA_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_we;
    logic                  r_loading;
    logic                  r_load_done;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_valid;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_is_halt;
    logic                  w_full;
    logic                  w_clear;
    logic [CNT_WIDTH-1:0]  w_count_inc;

    assign w_start_ok  = i_start && (r_state != ST_RECV) && (r_state != ST_WRITE);
    assign w_accept    = i_rx_done && ((r_state == ST_RECV) || (r_state == ST_WRITE));
    assign w_is_halt   = (w_word == HALT_WORD);
    assign w_count_inc = r_word_count + 1'b1;
    assign w_full      = (w_count_inc == CNT_WIDTH'(RAM_DEPTH));

    // A partial word is dropped both on a fresh start and when the load ends.
    assign w_clear = w_start_ok || ((r_state == ST_WRITE) && (w_is_halt || w_full));

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) begin
                    w_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_word_valid) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_is_halt) begin
                    w_next = ST_DONE;
                end else if (w_full) begin
                    w_next = ST_ERR;
                end else begin
                    w_next = ST_RECV;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the write strobe lines up
    // with the state register rather than being decoded after it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_word_count <= '0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_loading    <= 1'b0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_ram_we  <= (w_next == ST_WRITE);
            r_loading <= (w_next == ST_RECV) || (w_next == ST_WRITE);
            if (w_next == ST_WRITE) begin
                r_ram_addr <= DATA_WIDTH'(r_word_count);
            end
            if (w_start_ok) begin
                r_word_count <= '0;
                r_load_done  <= 1'b0;
                r_overflow   <= 1'b0;
            end else if (r_state == ST_WRITE) begin
                r_word_count <= w_count_inc;
                if (w_next == ST_DONE) begin
                    r_load_done <= 1'b1;
                end
                if (w_next == ST_ERR) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_ram_addr   = r_ram_addr;
    assign o_ram_data   = w_word;
    assign o_ram_we     = r_ram_we;
    assign o_ram_en     = r_ram_we;
    assign o_loading    = r_loading;
    assign o_load_done  = r_load_done;
    assign o_overflow   = r_overflow;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a small RAM so overflow is reachable;
// expected RAM writes are queued at stimulus time and checked as they appear.
module tb_instr_loader;

    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_done = 1'b0;
    logic [BW-1:0] rx_data = '0;

    logic [DW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_data;
    logic          o_ram_we;
    logic          o_ram_en;
    logic          o_loading;
    logic          o_load_done;
    logic          o_overflow;
    logic [CW-1:0] o_word_count;

    instr_loader #(
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (BW),
        .RAM_DEPTH  (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_ram_addr   (o_ram_addr),
        .o_ram_data   (o_ram_data),
        .o_ram_we     (o_ram_we),
        .o_ram_en     (o_ram_en),
        .o_loading    (o_loading),
        .o_load_done  (o_load_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cyc[$];
    wr_t e;
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  n_writes = 0;
    int  exp_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n && o_ram_we === 1'b1) begin
            n_writes++;
            wr_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected none", o_ram_addr, o_ram_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", o_ram_addr, e.addr);
                chk("wr_data", o_ram_data, e.data);
            end
            chk("wr_en", {31'd0, o_ram_en}, 32'd1);
            chk("wr_flags_low", {30'd0, o_load_done, o_overflow}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tick(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_wr, input int gap);
        if (expect_wr) begin
            exp_q.push_back('{addr: 32'(exp_addr), data: w});
            exp_addr++;
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, o_ram_addr, 32'd0);
        chk({tag, "_data"}, o_ram_data, 32'd0);
        chk({tag, "_ctl"}, {27'd0, o_ram_we, o_ram_en, o_loading, o_load_done, o_overflow}, 32'd0);
        chk({tag, "_count"}, 32'(o_word_count), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk_reset_outputs("reset");

        // Normal load
        n_writes = 0;
        pulse_start();
        chk("start_loading", {31'd0, o_loading}, 32'd1);
        send_word(32'h2008_0005, 1'b1, 1);
        send_word(32'hFFFF_FFFF, 1'b1, 0);
        chk("done_in_write_cycle", {31'd0, o_load_done}, 32'd0);
        tick(1);
        chk("done_after_write", {31'd0, o_load_done}, 32'd1);
        chk("done_loading_low", {31'd0, o_loading}, 32'd0);
        chk("done_count", 32'(o_word_count), 32'd2);
        tick(3);
        chk("normal_write_pulses", 32'(n_writes), 32'd2);
        chk("normal_q_empty", 32'(exp_q.size()), 32'd0);

        // Restart after DONE
        pulse_start();
        chk("restart_done_clr", {31'd0, o_load_done}, 32'd0);
        chk("restart_count_clr", 32'(o_word_count), 32'd0);
        send_word(32'hCAFE_F00D, 1'b1, 1);
        send_word(32'hFFFF_FFFF, 1'b1, 1);
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Strobes in IDLE are ignored
        do_reset();
        n_writes = 0;
        send_word(32'h1234_5678, 1'b0, 0);
        tick(3);
        chk("idle_no_write", 32'(n_writes), 32'd0);
        chk("idle_count", 32'(o_word_count), 32'd0);
        pulse_start();
        send_word(32'h0000_0001, 1'b1, 1);
        send_word(32'hFFFF_FFFF, 1'b1, 1);
        chk("idle_then_load_writes", 32'(n_writes), 32'd2);

        // Reset mid-word
        pulse_start();
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        do_reset();
        chk_reset_outputs("midreset");
        pulse_start();
        send_word(32'h0102_0304, 1'b1, 1);
        send_word(32'hFFFF_FFFF, 1'b1, 1);
        chk("midreset_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back bytes
        pulse_start();
        wr_cyc.delete();
        send_word(32'h0102_0304, 1'b1, 0);
        send_word(32'h0506_0708, 1'b1, 0);
        tick(2);
        chk("b2b_write_count", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() == 2) begin
            chk("b2b_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        end
        send_word(32'hFFFF_FFFF, 1'b1, 1);
        chk("b2b_done", {31'd0, o_load_done}, 32'd1);

        // Overflow with a 4-word RAM
        pulse_start();
        n_writes = 0;
        send_word(32'h1111_1111, 1'b1, 1);
        send_word(32'h2222_2222, 1'b1, 1);
        send_word(32'h3333_3333, 1'b1, 1);
        send_word(32'h4444_4444, 1'b1, 0);
        chk("ovf_in_write_cycle", {31'd0, o_overflow}, 32'd0);
        tick(1);
        chk("ovf_set", {31'd0, o_overflow}, 32'd1);
        chk("ovf_done_low", {31'd0, o_load_done}, 32'd0);
        chk("ovf_loading_low", {31'd0, o_loading}, 32'd0);
        chk("ovf_count", 32'(o_word_count), 32'd4);
        send_word(32'h5555_5555, 1'b0, 0);
        tick(3);
        chk("ovf_write_pulses", 32'(n_writes), 32'd4);
        chk("ovf_held", {31'd0, o_overflow}, 32'd1);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
